// File: rtl/mem_access_unit_if.sv
// Data-bus request/response types and the pipeline/bus interface of the
// load/store unit. Bus fields are sized for the widest (64-bit) configuration.
package mem_access_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic              op_valid;
  logic              op_ready;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [63:0]       op_addr;
  logic [DATA_W-1:0] op_wdata;
  dbus_req_t         dreq;
  dbus_resp_t        dresp;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              misalign;

  modport slave (
    input  op_valid, op_we, op_size, op_unsigned, op_addr, op_wdata, dresp,
    output op_ready, dreq, done, rdata, misalign
  );

  modport master (
    output op_valid, op_we, op_size, op_unsigned, op_addr, op_wdata, dresp,
    input  op_ready, dreq, done, rdata, misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one access at a time, drives the data bus until
// data_ok, and returns an extended load result or a misalignment error.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int         NB        = DATA_W / 8;
  localparam int         OFF_W     = $clog2(NB);
  localparam logic [7:0] LANE_MASK = (DATA_W == 64) ? 8'hFF : 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  dbus_req_t         dreq_q, dreq_d;

  // Request-side lane placement, computed from the op as presented at accept.
  logic [OFF_W-1:0]  op_off;
  logic [3:0]        op_bytes;
  logic [7:0]        op_mask;
  logic [7:0]        strb_sh;
  logic [DATA_W-1:0] wdata_sh;
  logic              op_bad;

  assign op_off   = bus.op_addr[OFF_W-1:0];
  assign op_bytes = 4'd1 << bus.op_size;
  assign op_mask  = 8'((9'd1 << op_bytes) - 9'd1);
  assign strb_sh  = op_mask << op_off;
  assign wdata_sh = bus.op_wdata << {op_off, 3'b000};
  assign op_bad   = (ALIGN_CHECK && ((4'(op_off) & (op_bytes - 4'd1)) != 4'd0))
                 || (DATA_W == 32 && bus.op_size == 2'd3);

  // Load-side: shift the addressed lanes down, then extend from the access size.
  logic [63:0] rd_raw;
  logic [63:0] rd_ext;

  assign rd_raw = 64'(bus.dresp.data[DATA_W-1:0]) >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    rd_ext = {{56{~uns_q & rd_raw[7]}},  rd_raw[7:0]};
      2'd1:    rd_ext = {{48{~uns_q & rd_raw[15]}}, rd_raw[15:0]};
      2'd2:    rd_ext = {{32{~uns_q & rd_raw[31]}}, rd_raw[31:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    misalign_d = misalign_q;
    rdata_d    = rdata_q;
    dreq_d     = dreq_q;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          we_d   = bus.op_we;
          size_d = bus.op_size;
          uns_d  = bus.op_unsigned;
          off_d  = op_off;
          if (op_bad) begin
            misalign_d = 1'b1;
            state_d    = RESP;
          end else begin
            state_d       = BUSY;
            dreq_d.valid  = 1'b1;
            dreq_d.addr   = bus.op_addr;
            dreq_d.size   = {1'b0, bus.op_size};
            dreq_d.strobe = bus.op_we ? (strb_sh & LANE_MASK) : 8'd0;
            dreq_d.data   = bus.op_we ? 64'(wdata_sh) : 64'd0;
          end
        end
      end
      BUSY: begin
        if (bus.dresp.data_ok) begin
          dreq_d  = '0;
          rdata_d = we_q ? '0 : rd_ext[DATA_W-1:0];
          state_d = RESP;
        end
      end
      RESP: begin
        state_d    = IDLE;
        misalign_d = 1'b0;
        rdata_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      dreq_q     <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
      dreq_q     <= dreq_d;
    end
  end

  assign bus.op_ready = (state_q == IDLE);
  assign bus.dreq     = dreq_q;
  assign bus.done     = (state_q == RESP);
  assign bus.rdata    = rdata_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, randomized accesses
// against a byte-lane reference model, back-to-back handshake and async reset.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DATA_W      = 64;
  localparam bit ALIGN_CHECK = 1'b1;
  localparam int NB          = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DATA_W)) bus_if ();

  mem_access_unit #(.DATA_W(DATA_W), .ALIGN_CHECK(ALIGN_CHECK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] last_rdata;
  logic [7:0]        last_strobe;
  logic [63:0]       last_data;

  // Reference model: byte-by-byte placement of each access onto bus lanes.
  function automatic void model_access(
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [63:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_data,
    output logic              mis,
    output logic [7:0]        strobe,
    output logic [63:0]       data,
    output logic [DATA_W-1:0] rdata
  );
    int nbytes;
    int off;
    nbytes = 1 << size;
    off    = int'(addr % NB);
    mis    = (ALIGN_CHECK && (off % nbytes) != 0) || (DATA_W == 32 && size == 2'd3);
    strobe = '0;
    data   = '0;
    rdata  = '0;
    if (we) begin
      for (int b = 0; b < nbytes; b++)
        if (off + b < NB) strobe[off+b] = 1'b1;
      for (int j = 0; j < NB; j++)
        if (off + j < NB) data[(off+j)*8 +: 8] = wdata[j*8 +: 8];
    end else if (!mis) begin
      for (int j = 0; j < nbytes; j++)
        if (off + j < NB) rdata[j*8 +: 8] = bus_data[(off+j)*8 +: 8];
      if (!uns && rdata[nbytes*8-1])
        for (int j = nbytes; j < NB; j++) rdata[j*8 +: 8] = 8'hFF;
    end
  endfunction

  task automatic do_access(
    input string             name,
    input logic              we,
    input logic [1:0]        size,
    input logic              uns,
    input logic [63:0]       addr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] bus_data,
    input int                waits
  );
    logic              e_mis;
    logic [7:0]        e_strb;
    logic [63:0]       e_data;
    logic [DATA_W-1:0] e_rdata;
    int                cyc;
    int                vcount;
    int                done_cyc;
    int                e_cyc;
    bit                got_done;

    model_access(we, size, uns, addr, wdata, bus_data, e_mis, e_strb, e_data, e_rdata);
    e_cyc       = e_mis ? 0 : waits + 1;
    last_strobe = 8'hA5;
    last_data   = 64'hDEAD_BEEF_DEAD_BEEF;
    last_rdata  = '1;

    checks++;
    if (bus_if.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s op_ready_idle got %b exp 1", name, bus_if.op_ready);
    end

    bus_if.op_we       = we;
    bus_if.op_size     = size;
    bus_if.op_unsigned = uns;
    bus_if.op_addr     = addr;
    bus_if.op_wdata    = wdata;
    bus_if.op_valid    = 1'b1;
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;

    cyc      = 0;
    vcount   = 0;
    done_cyc = -1;
    got_done = 1'b0;
    while (!got_done && cyc < 64) begin
      if (bus_if.dreq.valid === 1'b1) begin
        vcount++;
        last_strobe = bus_if.dreq.strobe;
        last_data   = bus_if.dreq.data;
        checks++;
        if ({bus_if.dreq.addr, bus_if.dreq.size, bus_if.dreq.strobe, bus_if.dreq.data}
            !== {addr, {1'b0, size}, e_strb, e_data}) begin
          errors++;
          $display("FAIL %s dreq got addr=%h size=%0d strb=%h data=%h exp addr=%h size=%0d strb=%h data=%h",
                   name, bus_if.dreq.addr, bus_if.dreq.size, bus_if.dreq.strobe, bus_if.dreq.data,
                   addr, size, e_strb, e_data);
        end
        checks++;
        if (bus_if.op_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s op_ready_busy got %b exp 0", name, bus_if.op_ready);
        end
        if (vcount == waits + 1) begin
          bus_if.dresp.data_ok = 1'b1;
          bus_if.dresp.data    = 64'(bus_data);
        end else begin
          bus_if.dresp.data_ok = 1'b0;
          bus_if.dresp.data    = {$urandom, $urandom};
        end
      end else begin
        bus_if.dresp.data_ok = 1'b0;
      end
      if (bus_if.done === 1'b1) begin
        got_done   = 1'b1;
        done_cyc   = cyc;
        last_rdata = bus_if.rdata;
        checks++;
        if ({bus_if.misalign, bus_if.rdata} !== {e_mis, e_rdata}) begin
          errors++;
          $display("FAIL %s result got misalign=%b rdata=%h exp misalign=%b rdata=%h",
                   name, bus_if.misalign, bus_if.rdata, e_mis, e_rdata);
        end
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus_if.dresp.data_ok = 1'b0;

    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s timeout got no done exp done within 64 cycles", name);
    end
    checks++;
    if (vcount != e_cyc || done_cyc != e_cyc) begin
      errors++;
      $display("FAIL %s timing got valid_cycles=%0d done_cycle=%0d exp %0d/%0d",
               name, vcount, done_cyc, e_cyc, e_cyc);
    end

    @(posedge clk); #1;
    checks++;
    if ({bus_if.done, bus_if.op_ready, bus_if.misalign} !== 3'b010) begin
      errors++;
      $display("FAIL %s after_done got done=%b ready=%b misalign=%b exp 0/1/0",
               name, bus_if.done, bus_if.op_ready, bus_if.misalign);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus_if.op_ready, bus_if.dreq, bus_if.done, bus_if.misalign, bus_if.rdata}
        !== {1'b1, {$bits(dbus_req_t){1'b0}}, 1'b0, 1'b0, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state got ready=%b dreq=%h done=%b misalign=%b rdata=%h exp 1/0/0/0/0",
               bus_if.op_ready, bus_if.dreq, bus_if.done, bus_if.misalign, bus_if.rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    bus_if.dresp.data_ok = 1'b1;
    bus_if.dresp.data    = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    bus_if.dresp.data_ok = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus_if.op_ready, bus_if.done, bus_if.dreq.valid, bus_if.rdata} !== {1'b1, 1'b0, 1'b0, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL idle_data_ok got ready=%b done=%b valid=%b rdata=%h exp 1/0/0/0",
               bus_if.op_ready, bus_if.done, bus_if.dreq.valid, bus_if.rdata);
    end
  endtask

  task automatic test_directed();
    do_access("ld_dword", 1'b0, 2'd3, 1'b0, 64'h8000_0008, '0, 64'h8877_6655_4433_2211, 2);
    checks++;
    if ({last_rdata, last_strobe} !== {64'h8877_6655_4433_2211, 8'h00}) begin
      errors++;
      $display("FAIL ld_dword_lit got rdata=%h strb=%h exp 8877665544332211/00", last_rdata, last_strobe);
    end
    do_access("lb_signed", 1'b0, 2'd0, 1'b0, 64'h8000_0003, '0, 64'h0000_0000_8000_0000, 0);
    checks++;
    if (last_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++;
      $display("FAIL lb_signed_lit got %h exp ffffffffffffff80", last_rdata);
    end
    do_access("lb_unsigned", 1'b0, 2'd0, 1'b1, 64'h8000_0003, '0, 64'h0000_0000_8000_0000, 0);
    checks++;
    if (last_rdata !== 64'h80) begin
      errors++;
      $display("FAIL lb_unsigned_lit got %h exp 80", last_rdata);
    end
    do_access("sh", 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hBEEF, '0, 1);
    checks++;
    if ({last_strobe, last_data, last_rdata} !== {8'hC0, 64'hBEEF_0000_0000_0000, 64'h0}) begin
      errors++;
      $display("FAIL sh_lit got strb=%h data=%h rdata=%h exp c0/beef000000000000/0",
               last_strobe, last_data, last_rdata);
    end
    do_access("lw_misalign", 1'b0, 2'd2, 1'b0, 64'h8000_0002, '0, 64'h1111_2222_3333_4444, 0);
    do_access("sd_misalign", 1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h5555, '0, 0);
  endtask

  task automatic test_random();
    logic [63:0] addr;
    logic [1:0]  size;
    for (int i = 0; i < 80; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = (addr >> size) << size;
      do_access($sformatf("rand%0d", i), 1'($urandom), size, 1'($urandom), addr,
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic              m1, m2;
    logic [7:0]        s1, s2;
    logic [63:0]       d1x, d2x;
    logic [DATA_W-1:0] r1, r2;
    logic [DATA_W-1:0] b1, b2;
    bit                exp_done;
    bit                exp_ready;

    b1 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    model_access(1'b0, 2'd2, 1'b0, 64'h4000_0014, '0, b1, m1, s1, d1x, r1);
    model_access(1'b0, 2'd1, 1'b1, 64'h4000_001A, '0, b2, m2, s2, d2x, r2);

    bus_if.op_we       = 1'b0;
    bus_if.op_size     = 2'd2;
    bus_if.op_unsigned = 1'b0;
    bus_if.op_addr     = 64'h4000_0014;
    bus_if.op_valid    = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      exp_done  = (k == 1 || k == 4);
      exp_ready = (k == 2 || k == 5);
      checks++;
      if ({bus_if.done, bus_if.op_ready} !== {exp_done, exp_ready}) begin
        errors++;
        $display("FAIL b2b_cycle%0d got done=%b ready=%b exp %b/%b",
                 k, bus_if.done, bus_if.op_ready, exp_done, exp_ready);
      end
      if (bus_if.done === 1'b1) begin
        checks++;
        if (bus_if.rdata !== ((k < 2) ? r1 : r2)) begin
          errors++;
          $display("FAIL b2b_rdata%0d got %h exp %h", k, bus_if.rdata, (k < 2) ? r1 : r2);
        end
      end
      bus_if.dresp.data_ok = bus_if.dreq.valid;
      bus_if.dresp.data    = 64'((k < 2) ? b1 : b2);
      if (k == 0) begin
        bus_if.op_size     = 2'd1;
        bus_if.op_unsigned = 1'b1;
        bus_if.op_addr     = 64'h4000_001A;
      end
      if (k == 3) bus_if.op_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.dresp.data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bit saw_done;
    bus_if.op_we       = 1'b0;
    bus_if.op_size     = 2'd3;
    bus_if.op_unsigned = 1'b0;
    bus_if.op_addr     = 64'h8000_0020;
    bus_if.op_valid    = 1'b1;
    @(posedge clk); #1;
    bus_if.op_valid      = 1'b0;
    bus_if.dresp.data_ok = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.dreq.valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre got valid=%b exp 1", bus_if.dreq.valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_if.dreq.valid, bus_if.op_ready, bus_if.done} !== 3'b010) begin
      errors++;
      $display("FAIL rst_busy_async got valid=%b ready=%b done=%b exp 0/1/0",
               bus_if.dreq.valid, bus_if.op_ready, bus_if.done);
    end
    saw_done = 1'b0;
    @(posedge clk); #1;
    saw_done |= bus_if.done;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      saw_done |= bus_if.done;
    end
    checks++;
    if (saw_done || bus_if.dreq.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_abandon got done_seen=%b valid=%b exp 0/0", saw_done, bus_if.dreq.valid);
    end
    do_access("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h8000_0028, '0, 64'hCAFE_F00D_0123_4567, 1);
  endtask

  initial begin
    bus_if.op_valid    = 1'b0;
    bus_if.op_we       = 1'b0;
    bus_if.op_size     = 2'd0;
    bus_if.op_unsigned = 1'b0;
    bus_if.op_addr     = '0;
    bus_if.op_wdata    = '0;
    bus_if.dresp       = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
